// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and 8N1 frame geometry,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;

  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: emits a one-clock tick on the last clock of every DIV-clock
// period; a synchronous clear restarts the period from zero.
module uart_baud_tick #(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic rstN,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : genDivCheck
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register in the design samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx8.sv
// 8N1 UART transmitter: latches a byte on request and shifts it out LSB first
// between a start and a stop bit, each bit lasting CLOCK_RATE/BAUD_RATE clocks.
module uart_tx8
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] txIn,
  output logic       txOut,
  output logic       txBusy,
  output logic       txDone
);

  localparam int DIV      = CLOCK_RATE / BAUD_RATE;
  localparam int IW       = $clog2(DATA_BITS);
  localparam int LAST_BIT = DATA_BITS - 1;

  uartState_t             state;
  logic [DATA_BITS-1:0]   shiftReg;
  logic [IW-1:0]          bitIdx;
  logic                   baudTick;
  logic                   baudClear;

  // The timer is held clear in IDLE, and every other state change happens on
  // a tick, where the timer wraps to zero, so each state starts a full period.
  assign baudClear = (state == IDLE);

  uart_baud_tick #(
    .DIV (DIV)
  ) uBaud (
    .clk   (clk),
    .rstN  (rstN),
    .clear (baudClear),
    .tick  (baudTick)
  );

  // txOut, txBusy and txDone are all registers so the line never glitches.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitIdx   <= '0;
      txOut    <= 1'b1;
      txBusy   <= 1'b0;
      txDone   <= 1'b0;
    end else begin
      txDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (txEn && txStart) begin
            shiftReg <= txIn;
            bitIdx   <= '0;
            txOut    <= 1'b0;
            txBusy   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baudTick) begin
            txOut    <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (baudTick) begin
            if (bitIdx == IW'(LAST_BIT)) begin
              txOut <= 1'b1;
              state <= STOP;
            end else begin
              txOut    <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitIdx   <= bitIdx + IW'(1);
            end
          end
        end
        STOP: begin
          if (baudTick) begin
            txBusy <= 1'b0;
            txDone <= 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx8.sv
// Self-checking bench for uart_tx8: cycle-exact frame checks from a vector
// table, hand-written corner sequences, and a line receiver fed by a scoreboard.
module tb_uart_tx8;

  // Clock rate is scaled down so frames stay short; 1250000/9600 truncates to 130.
  localparam int CLOCK_RATE = 1250000;
  localparam int BAUD_RATE  = 9600;
  localparam int DIV        = 130;

  logic       clk = 1'b0;
  logic       rstN;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txOut;
  logic       txBusy;
  logic       txDone;

  int nTests = 0;
  int nFail  = 0;

  logic [7:0] expQ[$];

  typedef struct {
    logic [7:0] data;
    logic [0:9] line;
    string      tag;
  } frameVec_t;

  frameVec_t vecs[4];

  uart_tx8 #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk     (clk),
    .rstN    (rstN),
    .txEn    (txEn),
    .txStart (txStart),
    .txIn    (txIn),
    .txOut   (txOut),
    .txBusy  (txBusy),
    .txDone  (txDone)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", nTests, nFail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Line receiver: samples each bit mid-period, compares against the scoreboard.
  logic       rxActive = 1'b0;
  logic       prevLine = 1'b1;
  logic [7:0] rxByte   = '0;
  int         rxCnt    = 0;
  int         doneCnt  = 0;

  always @(negedge clk) begin
    if (rstN !== 1'b1) begin
      rxActive = 1'b0;
      rxCnt    = 0;
      prevLine = 1'b1;
    end else begin
      if (!rxActive) begin
        if (prevLine === 1'b1 && txOut === 1'b0) begin
          rxActive = 1'b1;
          rxCnt    = 0;
        end
      end else begin
        rxCnt++;
      end
      if (rxActive && (rxCnt % DIV) == DIV / 2) begin
        if (rxCnt / DIV == 0) begin
          check("rx start bit", 32'(txOut), 32'd0);
        end else if (rxCnt / DIV <= 8) begin
          rxByte = {txOut, rxByte[7:1]};
        end else begin
          check("rx stop bit", 32'(txOut), 32'd1);
          if (expQ.size() == 0) begin
            check("rx unexpected frame", 32'(rxByte), 32'hFFFF_FFFF);
          end else begin
            check("rx byte", 32'(rxByte), 32'(expQ.pop_front()));
          end
          rxActive = 1'b0;
        end
      end
      prevLine = txOut;
      if (txDone === 1'b1) doneCnt++;
    end
  end

  // Sends one byte and checks the line cycle by cycle. With atEdge set the
  // request is raised at the current falling edge (the previous txDone cycle).
  // Returns at the falling edge of the txDone cycle.
  task automatic sendFrame(input logic [7:0] data, input logic [0:9] expLine,
                           input string tag, input bit atEdge);
    int match[10];
    int busyCycles;
    for (int b = 0; b < 10; b++) match[b] = 0;
    busyCycles = 0;
    if (!atEdge) @(negedge clk);
    txIn    = data;
    txStart = 1'b1;
    expQ.push_back(data);
    @(negedge clk);
    txStart = 1'b0;
    txIn    = ~data;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (k != 0) @(negedge clk);
      if (txOut === expLine[k / DIV]) match[k / DIV]++;
      if (txBusy === 1'b1) busyCycles++;
    end
    for (int b = 0; b < 10; b++) begin
      check($sformatf("%s bit%0d cycles", tag, b), 32'(match[b]), 32'(DIV));
    end
    check({tag, " busy cycles"}, 32'(busyCycles), 32'(10 * DIV));
    @(negedge clk);
    check({tag, " txDone pulse"}, 32'(txDone), 32'd1);
    check({tag, " txBusy in done cycle"}, 32'(txBusy), 32'd0);
    check({tag, " line idle after stop"}, 32'(txOut), 32'd1);
  endtask

  initial begin
    int idleOk;

    vecs[0] = '{data: 8'h35, line: 10'b0101011001, tag: "byte35"};
    vecs[1] = '{data: 8'h55, line: 10'b0101010101, tag: "byte55"};
    vecs[2] = '{data: 8'hFF, line: 10'b0111111111, tag: "byteFF"};
    vecs[3] = '{data: 8'h00, line: 10'b0000000001, tag: "byte00"};

    rstN    = 1'b0;
    txEn    = 1'b0;
    txStart = 1'b0;
    txIn    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset txOut", 32'(txOut), 32'd1);
    check("reset txBusy", 32'(txBusy), 32'd0);
    check("reset txDone", 32'(txDone), 32'd0);

    rstN = 1'b1;
    txEn = 1'b1;
    @(negedge clk);
    check("idle txOut after release", 32'(txOut), 32'd1);

    for (int i = 0; i < 4; i++) begin
      sendFrame(vecs[i].data, vecs[i].line, vecs[i].tag, 1'b0);
    end
    @(negedge clk);
    check("txDone drops after one cycle", 32'(txDone), 32'd0);

    // Back-to-back: the second request is raised in the first frame's txDone cycle.
    sendFrame(8'hA5, 10'b0101001011, "b2bA5", 1'b0);
    sendFrame(8'h3C, 10'b0001111001, "b2b3C", 1'b1);

    // Mid-frame request with 8'hFF is ignored; txEn falls during DATA.
    fork
      sendFrame(8'h0F, 10'b0111100001, "busy0F", 1'b0);
      begin
        repeat (3 * DIV) @(negedge clk);
        txIn    = 8'hFF;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        repeat (DIV) @(negedge clk);
        txEn = 1'b0;
      end
    join

    // With txEn low a request gets no response.
    @(negedge clk);
    txIn    = 8'h81;
    txStart = 1'b1;
    idleOk  = 0;
    for (int k = 0; k < 2 * DIV; k++) begin
      @(negedge clk);
      txStart = 1'b0;
      if (txBusy === 1'b0 && txOut === 1'b1) idleOk++;
    end
    check("disabled request ignored", 32'(idleOk), 32'(2 * DIV));
    txEn = 1'b1;

    // Reset at roughly 4 bit periods into a frame.
    @(negedge clk);
    txIn    = 8'hC3;
    txStart = 1'b1;
    expQ.push_back(8'hC3);
    @(negedge clk);
    txStart = 1'b0;
    repeat (4 * DIV - 1) @(negedge clk);
    check("pre-reset busy", 32'(txBusy), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    check("async reset txOut", 32'(txOut), 32'd1);
    check("async reset txBusy", 32'(txBusy), 32'd0);
    check("async reset txDone", 32'(txDone), 32'd0);
    expQ.delete();
    repeat (3) @(negedge clk);
    check("txDone held low in reset", 32'(txDone), 32'd0);
    rstN = 1'b1;
    sendFrame(8'h00, 10'b0000000001, "postReset00", 1'b0);

    repeat (DIV) @(negedge clk);
    check("txDone pulse count", 32'(doneCnt), 32'd8);
    check("scoreboard drained", 32'(expQ.size()), 32'd0);
    check("receiver idle at end", 32'(rxActive), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
